// File: rtl/risc16_pkg.sv
// Shared types and defaults for the 16-bit RISC core front end.
package risc16_pkg;

  localparam int unsigned INST_W     = 16;
  localparam int unsigned DEF_ADDR_W = 16;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_e;

endpackage : risc16_pkg

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: run/stall/branch control, instruction memory port, decoder port.
interface inst_fetch_if
  import risc16_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
);
  logic              i_en;
  logic              i_stall;
  logic              i_branch;
  logic [ADDR_W-1:0] i_branch_target;
  logic              o_mem_req;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [INST_W-1:0] i_mem_rdata;
  logic              i_mem_ready;
  logic [INST_W-1:0] o_inst;
  logic              o_inst_valid;
  logic [ADDR_W-1:0] o_pc;

  // Fetch unit side.
  modport master (
    input  i_en, i_stall, i_branch, i_branch_target, i_mem_rdata, i_mem_ready,
    output o_mem_req, o_mem_addr, o_inst, o_inst_valid, o_pc
  );

  // Environment side: memory, decoder and pipeline control.
  modport slave (
    output i_en, i_stall, i_branch, i_branch_target, i_mem_rdata, i_mem_ready,
    input  o_mem_req, o_mem_addr, o_inst, o_inst_valid, o_pc
  );
endinterface : inst_fetch_if

// File: rtl/inst_fetch_pc_reg.sv
// Program counter register: async reset, load has priority over increment.
module pc_reg #(
  parameter int unsigned W         = 16,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  // Load wins over increment; increment wraps modulo 2^W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (inc) begin
      q <= q + W'(1);
    end
  end

endmodule : pc_reg

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, memory read handshake and decoder hand-off with stall/branch.
module inst_fetch
  import risc16_pkg::*;
#(
  parameter int unsigned      ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  inst_fetch_if.master  bus
);

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [ADDR_W-1:0] pc_q;
  logic              pc_load;
  logic              pc_inc;
  logic              capture;
  logic              drop;
  logic [INST_W-1:0] inst_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic              valid_q;

  pc_reg #(
    .W         (ADDR_W),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (bus.i_branch_target),
    .q        (pc_q)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath strobes; a branch overrides everything in any state.
  always_comb begin
    state_d = state_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    capture = 1'b0;
    drop    = 1'b0;
    if (bus.i_branch) begin
      pc_load = 1'b1;
      drop    = 1'b1;
      state_d = bus.i_en ? ST_REQ : ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.i_en) state_d = ST_REQ;
        end
        ST_REQ: begin
          if (bus.i_mem_ready) begin
            capture = 1'b1;
            pc_inc  = 1'b1;
            state_d = ST_VALID;
          end
        end
        ST_VALID: begin
          if (!bus.i_stall) begin
            drop    = 1'b1;
            state_d = bus.i_en ? ST_REQ : ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Decoder-facing registers: capture on memory ready, clear on consume or branch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inst_q    <= '0;
      inst_pc_q <= RESET_PC;
      valid_q   <= 1'b0;
    end else if (capture) begin
      inst_q    <= bus.i_mem_rdata;
      inst_pc_q <= pc_q;
      valid_q   <= 1'b1;
    end else if (drop) begin
      valid_q   <= 1'b0;
    end
  end

  assign bus.o_mem_req    = (state_q == ST_REQ);
  assign bus.o_mem_addr   = pc_q;
  assign bus.o_inst       = inst_q;
  assign bus.o_inst_valid = valid_q;
  assign bus.o_pc         = inst_pc_q;

endmodule : inst_fetch

// File: tb/tb_inst_fetch.sv
// Randomized scoreboard bench for inst_fetch against a transaction-level model.
module tb_inst_fetch;
  import risc16_pkg::*;

  localparam int unsigned      AW  = 16;
  localparam logic [AW-1:0]    RPC = 16'h0000;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [15:0]   inst;
  } exp_t;

  logic clk;
  logic rst_n;
  inst_fetch_if #(.ADDR_W(AW)) bus ();

  inst_fetch #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  // Model: next address to fetch, request outstanding, instruction held.
  logic [AW-1:0] m_pc;
  bit            m_req;
  bit            m_hold;

  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    if (a == '0) return 16'h1704;
    return 16'(a * 16'h9E37) ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = RPC;
    m_req  = 1'b0;
    m_hold = 1'b0;
    exp_q.delete();
  endtask

  // One cycle: check outputs vs model at negedge, drive inputs, advance model.
  task automatic step(input bit en, input bit stall, input bit br,
                      input logic [AW-1:0] tgt, input bit rdy);
    @(negedge clk);
    chk("mem_req", 32'(bus.o_mem_req), 32'(m_req));
    if (m_req) chk("mem_addr", 32'(bus.o_mem_addr), 32'(m_pc));
    chk("inst_valid", 32'(bus.o_inst_valid), 32'(m_hold));
    bus.i_en            = en;
    bus.i_stall         = stall;
    bus.i_branch        = br;
    bus.i_branch_target = tgt;
    bus.i_mem_ready     = rdy;
    bus.i_mem_rdata     = rdy ? mem_word(bus.o_mem_addr) : 16'hDEAD;
    if (br) begin
      m_pc   = tgt;
      m_hold = 1'b0;
      m_req  = en;
    end else if (m_req) begin
      if (rdy) begin
        exp_q.push_back('{pc: m_pc, inst: mem_word(m_pc)});
        m_pc   = m_pc + AW'(1);
        m_req  = 1'b0;
        m_hold = 1'b1;
      end
    end else if (m_hold) begin
      if (!stall) begin
        m_hold = 1'b0;
        m_req  = en;
      end
    end else begin
      m_req = en;
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!m_req && n < 20) begin
      step(1'b1, 1'b0, 1'b0, '0, 1'b0);
      n++;
    end
    if (!m_req) begin
      checks++;
      failures++;
      $display("FAIL wait_req_timeout actual=%0d required=1", m_req);
    end
  endtask

  task automatic wait_hold();
    int n = 0;
    while (!m_hold && n < 20) begin
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      n++;
    end
    if (!m_hold) begin
      checks++;
      failures++;
      $display("FAIL wait_hold_timeout actual=%0d required=1", m_hold);
    end
  endtask

  // Monitor: each rising o_inst_valid is a new delivery; held values must stay put.
  bit   prev_valid = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.o_inst_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_inst actual=pc %h inst %h required=none", bus.o_pc, bus.o_inst);
        end else begin
          cur = exp_q.pop_front();
          chk("o_pc", 32'(bus.o_pc), 32'(cur.pc));
          chk("o_inst", 32'(bus.o_inst), 32'(cur.inst));
        end
      end else if (bus.o_inst_valid && prev_valid) begin
        chk("held_pc", 32'(bus.o_pc), 32'(cur.pc));
        chk("held_inst", 32'(bus.o_inst), 32'(cur.inst));
      end
      prev_valid = bus.o_inst_valid;
    end
  end

  initial begin
    rst_n               = 1'b0;
    bus.i_en            = 1'b0;
    bus.i_stall         = 1'b0;
    bus.i_branch        = 1'b0;
    bus.i_branch_target = '0;
    bus.i_mem_ready     = 1'b0;
    bus.i_mem_rdata     = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mem_req", 32'(bus.o_mem_req), 32'd0);
    chk("rst_mem_addr", 32'(bus.o_mem_addr), 32'(RPC));
    chk("rst_inst", 32'(bus.o_inst), 32'h0);
    chk("rst_valid", 32'(bus.o_inst_valid), 32'd0);
    chk("rst_pc", 32'(bus.o_pc), 32'(RPC));

    // Zero-wait memory streaming from address 0.
    repeat (8) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Three wait states before ready.
    wait_req();
    repeat (3) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Five stall cycles in VALID; ready toggled to show it is ignored there.
    wait_hold();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, '0, 1'(i & 1));
    repeat (4) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Branch while memory answers: data dropped, refetch at target.
    wait_req();
    step(1'b1, 1'b0, 1'b1, 16'h0040, 1'b1);
    repeat (4) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Branch dropping a stalled instruction.
    wait_hold();
    step(1'b1, 1'b1, 1'b1, 16'h0123, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // PC wrap at the top of the address space.
    step(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    repeat (6) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Branch while idle with fetch disabled, then resume.
    repeat (4) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Asynchronous reset between edges while requesting.
    wait_req();
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(bus.o_mem_req), 32'd0);
    chk("async_rst_valid", 32'(bus.o_inst_valid), 32'd0);
    chk("async_rst_addr", 32'(bus.o_mem_addr), 32'(RPC));
    model_reset();
    @(negedge clk);
    bus.i_en        = 1'b0;
    bus.i_mem_ready = 1'b0;
    rst_n = 1'b1;
    repeat (4) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 19) == 0), AW'($urandom), ($urandom_range(0, 4) > 1));
    end

    // Drain and confirm every predicted instruction was delivered.
    repeat (10) step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_inst_fetch
